// File: rtl/gpu_apb_master.sv
// APB write initiator for the GPU slave port: host commands queue in a FIFO and replay as APB writes.
// Optional GPU_APB_MASTER_PREADY_EN adds pReady_i wait-state support in ACCESS.
module gpu_apb_master #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       cmd_valid_i,
  input  logic [ADDR_W-1:0]          cmd_addr_i,
  input  logic [DATA_W-1:0]          cmd_data_i,
`ifdef GPU_APB_MASTER_PREADY_EN
  input  logic                       pReady_i,
`endif
  output logic                       cmd_ready_o,
  output logic [ADDR_W-1:0]          pAddr_o,
  output logic [DATA_W-1:0]          pDataWrite_o,
  output logic                       pSel_o,
  output logic                       pEnable_o,
  output logic                       pWrite_o,
  output logic [$clog2(DEPTH):0]     fifo_count_o,
  output logic                       busy_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr_mem [DEPTH];
  logic [DATA_W-1:0] r_data_mem [DEPTH];
  logic [PW-1:0]     r_wptr, r_rptr;
  logic [CW-1:0]     r_count;

  logic w_full, w_push, w_pop, w_done;

`ifdef GPU_APB_MASTER_PREADY_EN
  assign w_done = pReady_i;
`else
  assign w_done = 1'b1;
`endif

  // full comes from the registered count only, so ready never depends on valid
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_push  = cmd_valid_i && !w_full;
  assign w_pop   = (r_count != '0) &&
                   ((r_state == IDLE) || ((r_state == ACCESS) && w_done));

  assign cmd_ready_o  = !w_full;
  assign fifo_count_o = r_count;
  assign busy_o       = (r_state != IDLE) || (r_count != '0);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr_mem[r_wptr] <= cmd_addr_i;
      r_data_mem[r_wptr] <= cmd_data_i;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state      <= IDLE;
      pAddr_o      <= '0;
      pDataWrite_o <= '0;
      pSel_o       <= 1'b0;
      pEnable_o    <= 1'b0;
      pWrite_o     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            pAddr_o      <= r_addr_mem[r_rptr];
            pDataWrite_o <= r_data_mem[r_rptr];
            pSel_o       <= 1'b1;
            pEnable_o    <= 1'b0;
            pWrite_o     <= 1'b1;
            r_state      <= SETUP;
          end
        end
        SETUP: begin
          pEnable_o <= 1'b1;
          r_state   <= ACCESS;
        end
        ACCESS: begin
          // back-to-back transfers skip IDLE and keep pSel_o asserted
          if (w_done) begin
            if (w_pop) begin
              pAddr_o      <= r_addr_mem[r_rptr];
              pDataWrite_o <= r_data_mem[r_rptr];
              pEnable_o    <= 1'b0;
              r_state      <= SETUP;
            end else begin
              pSel_o    <= 1'b0;
              pEnable_o <= 1'b0;
              pWrite_o  <= 1'b0;
              r_state   <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gpu_apb_master.sv
// Scoreboard bench for gpu_apb_master: pushes queue expected writes, a negedge monitor checks completed APB writes.
module tb_gpu_apb_master;
  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_data = '0;
  logic        pReady = 1'b1;
  logic        cmd_ready_o;
  logic [31:0] pAddr_o, pDataWrite_o;
  logic        pSel_o, pEnable_o, pWrite_o, busy_o;
  logic [3:0]  fifo_count_o;

  int checks = 0;
  int errors = 0;
  int completions = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  gpu_apb_master #(.DEPTH(8), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .n_rst(n_rst),
    .cmd_valid_i(cmd_valid), .cmd_addr_i(cmd_addr), .cmd_data_i(cmd_data),
`ifdef GPU_APB_MASTER_PREADY_EN
    .pReady_i(pReady),
`endif
    .cmd_ready_o(cmd_ready_o), .pAddr_o(pAddr_o), .pDataWrite_o(pDataWrite_o),
    .pSel_o(pSel_o), .pEnable_o(pEnable_o), .pWrite_o(pWrite_o),
    .fifo_count_o(fifo_count_o), .busy_o(busy_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = a; cmd_data = d;
    while (!cmd_ready_o && n < 100) begin @(negedge clk); n++; end
    if (!cmd_ready_o) begin
      checks++; errors++;
      $display("FAIL push_timeout: ready stuck low for addr 0x%0h", a);
      cmd_valid = 1'b0;
      return;
    end
    exp_q.push_back({a, d});
    @(posedge clk); #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy_o || exp_q.size() != 0) && n < 500) begin @(negedge clk); n++; end
    check(name, 64'(exp_q.size()), 64'd0);
    check({name, "_busy"}, 64'(busy_o), 64'd0);
  endtask

  // Completed write = pSel & pEnable (& pReady) sampled mid-cycle
  always @(negedge clk) begin
    if (n_rst && pSel_o && pEnable_o && pReady) begin
      completions++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, scoreboard empty", pAddr_o, pDataWrite_o);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({pAddr_o, pDataWrite_o} !== e || pWrite_o !== 1'b1) begin
          errors++;
          $display("FAIL write_order: got 0x%0h/0x%0h pWrite=%0b, expected 0x%0h/0x%0h pWrite=1",
                   pAddr_o, pDataWrite_o, pWrite_o, e[63:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    int n;
    bit seen_full;
    bit rel_checked;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 64'(cmd_ready_o), 64'd1);
    check("rst_strobes", 64'({pSel_o, pEnable_o, pWrite_o}), 64'd0);
    check("rst_count", 64'(fifo_count_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    @(negedge clk); n_rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_strobes", 64'({pSel_o, pEnable_o, pWrite_o}), 64'd0);
    check("idle_busy", 64'(busy_o), 64'd0);

    // single transfer latency
    push(32'h0000_0004, 32'h00FF_00AA);
    check("e0_count", 64'(fifo_count_o), 64'd1);
    check("e0_busy", 64'(busy_o), 64'd1);
    @(posedge clk); #1;
    check("e1_sel_en_wr", 64'({pSel_o, pEnable_o, pWrite_o}), 64'b101);
    check("e1_addr", 64'(pAddr_o), 64'h4);
    check("e1_count", 64'(fifo_count_o), 64'd0);
    @(posedge clk); #1;
    check("e2_sel_en", 64'({pSel_o, pEnable_o}), 64'b11);
    check("e2_data", 64'(pDataWrite_o), 64'h00FF_00AA);
    @(posedge clk); #1;
    check("e3_strobes", 64'({pSel_o, pEnable_o, pWrite_o}), 64'd0);
    check("e3_busy", 64'(busy_o), 64'd0);
    check("e3_addr_held", 64'(pAddr_o), 64'h4);
    wait_idle("single_drain");

    // 8 back-to-back commands: pSel continuous for 16 cycles, pEnable alternating
    fork
      for (int i = 0; i < 8; i++) push(32'h100 + 32'(i * 4), 32'hA000_0000 + 32'(i));
      begin
        n = 0;
        do begin @(negedge clk); n++; end while (!pSel_o && n < 30);
        for (int c = 0; c < 16; c++) begin
          if (c != 0) @(negedge clk);
          check("b2b_sel", 64'(pSel_o), 64'd1);
          check("b2b_en", 64'(pEnable_o), 64'(c % 2));
        end
        @(negedge clk);
        check("b2b_release", 64'(pSel_o), 64'd0);
      end
    join
    wait_idle("b2b_drain");

    // fill to full while draining
    seen_full = 0; rel_checked = 0;
    fork
      for (int i = 0; i < 20; i++) push(32'h2000 + 32'(i * 4), 32'h5A00_0000 + 32'(i * 3));
      begin
        for (int c = 0; c < 300 && !rel_checked; c++) begin
          @(negedge clk);
          if (fifo_count_o == 4'd8) begin
            if (!seen_full) begin
              check("full_ready", 64'(cmd_ready_o), 64'd0);
              check("full_inflight", 64'(pSel_o), 64'd1);
            end
            seen_full = 1;
          end else if (seen_full) begin
            check("full_release_ready", 64'(cmd_ready_o), 64'd1);
            check("full_release_count", 64'(fifo_count_o), 64'd7);
            rel_checked = 1;
          end
        end
        check("full_reached", 64'(rel_checked), 64'd1);
      end
    join
    wait_idle("full_drain");

    // reset during ACCESS of 3rd of 5 queued writes
    base = completions;
    for (int i = 0; i < 5; i++) push(32'h3000 + 32'(i * 4), 32'hDEAD_0000 + 32'(i));
    n = 0;
    while (completions < base + 2 && n < 100) begin @(posedge clk); n++; end
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!(pSel_o && pEnable_o) && n < 20);
    check("rst3_in_access", 64'(pAddr_o), 64'h3008);
    n_rst = 1'b0;
    #1;
    check("rst3_strobes", 64'({pSel_o, pEnable_o, pWrite_o}), 64'd0);
    check("rst3_count", 64'(fifo_count_o), 64'd0);
    check("rst3_busy", 64'(busy_o), 64'd0);
    check("rst3_ready", 64'(cmd_ready_o), 64'd1);
    check("rst3_done", 64'(completions), 64'(base + 2));
    exp_q.delete();
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    push(32'h4000, 32'h1111_2222);
    push(32'h4004, 32'h3333_4444);
    wait_idle("post_rst_drain");
    check("post_rst_writes", 64'(completions), 64'(base + 4));

`ifdef GPU_APB_MASTER_PREADY_EN
    begin
      logic [31:0] a0, d0;
      push(32'h5000, 32'hCAFE_0001);
      push(32'h5004, 32'hCAFE_0002);
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!pEnable_o && n < 20);
      pReady = 1'b0;
      a0 = pAddr_o; d0 = pDataWrite_o;
      check("stall_first_addr", 64'(a0), 64'h5000);
      for (int c = 0; c < 4; c++) begin
        @(posedge clk); #1;
        check("stall_en", 64'({pSel_o, pEnable_o}), 64'b11);
        check("stall_addr", 64'(pAddr_o), 64'(a0));
        check("stall_data", 64'(pDataWrite_o), 64'(d0));
      end
      pReady = 1'b1;
      @(posedge clk); #1;
      check("stall_next_setup", 64'({pSel_o, pEnable_o}), 64'b10);
      check("stall_next_addr", 64'(pAddr_o), 64'h5004);
      wait_idle("stall_drain");
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
